// File: rtl/mem_refill_arbiter.sv
// mem_refill_arbiter
// Shares one backing-memory read port between NUM_REQ cache controllers.
// Requesters are granted one at a time in round-robin order. The returned
// line is broadcast on req_data and tagged with a one-hot req_data_valid.
// A per-transaction watchdog abandons a read whose response never arrives.
//
// State table
//   state   | meaning
//   IDLE    | no owner; arbitrate among pending requests
//   BUSY    | read outstanding at memory, mem_rd_en held high
//   RESP    | line delivered to the owner this cycle; release next
//
// Ports
//   clk             in   rising-edge clock
//   rst             in   asynchronous active-high reset
//   req_rd_en       in   per-requester level read request
//   req_addr        in   requester i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   grant           out  one-hot owner of the memory port (zero when idle)
//   req_data        out  returned line, held until the next capture
//   req_data_valid  out  one-hot, one-cycle delivery strobe
//   mem_rd_en       out  memory read request, high from grant to response
//   mem_addr        out  address latched from the owner at grant
//   mem_data        in   memory read data
//   mem_data_valid  in   mem_data valid this cycle
//   timeout_err     out  one-cycle pulse when the watchdog abandons a read
module mem_refill_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_rd_en,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            grant,
  output logic [DATA_WIDTH-1:0]         req_data,
  output logic [NUM_REQ-1:0]            req_data_valid,
  output logic                          mem_rd_en,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  input  logic [DATA_WIDTH-1:0]         mem_data,
  input  logic                          mem_data_valid,
  output logic                          timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  // A zero TIMEOUT would give a zero-width counter; keep one bit so the
  // logic stays legal, the fire condition is gated off separately.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] WD_MAX  = {CNT_W{1'b1}};
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_t;

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       last, last_nxt;
  logic [CNT_W-1:0]       wd_cnt, wd_cnt_nxt;
  logic [NUM_REQ-1:0]     grant_nxt;
  logic [DATA_WIDTH-1:0]  req_data_nxt;
  logic [NUM_REQ-1:0]     req_data_valid_nxt;
  logic                   mem_rd_en_nxt;
  logic [ADDR_WIDTH-1:0]  mem_addr_nxt;
  logic                   timeout_err_nxt;

  logic                   hi_hit, any_hit;
  logic [IDX_W-1:0]       hi_idx, any_idx, winner;
  logic [ADDR_WIDTH-1:0]  win_addr;

  // Round-robin: the lowest pending index above last wins; failing that,
  // wrap around to the lowest pending index overall. Descending loops leave
  // the lowest matching index as the final assignment.
  always_comb begin
    hi_hit   = 1'b0;
    hi_idx   = '0;
    any_hit  = 1'b0;
    any_idx  = '0;
    win_addr = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rd_en[i] && (IDX_W'(i) > last)) begin
        hi_hit = 1'b1;
        hi_idx = IDX_W'(i);
      end
      if (req_rd_en[i]) begin
        any_hit = 1'b1;
        any_idx = IDX_W'(i);
      end
    end
    winner = hi_hit ? hi_idx : any_idx;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == winner) begin
        win_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  always_comb begin
    state_nxt          = state;
    last_nxt           = last;
    wd_cnt_nxt         = wd_cnt;
    grant_nxt          = grant;
    req_data_nxt       = req_data;
    req_data_valid_nxt = '0;
    mem_rd_en_nxt      = mem_rd_en;
    mem_addr_nxt       = mem_addr;
    timeout_err_nxt    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (any_hit) begin
          grant_nxt         = '0;
          grant_nxt[winner] = 1'b1;
          mem_addr_nxt      = win_addr;
          mem_rd_en_nxt     = 1'b1;
          last_nxt          = winner;
          wd_cnt_nxt        = '0;
          state_nxt         = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Data arriving on the firing cycle takes priority over the watchdog.
        if (mem_data_valid) begin
          req_data_nxt       = mem_data;
          req_data_valid_nxt = grant;
          mem_rd_en_nxt      = 1'b0;
          state_nxt          = ST_RESP;
        end else if ((TIMEOUT != 0) && (wd_cnt == WD_LAST)) begin
          grant_nxt       = '0;
          mem_rd_en_nxt   = 1'b0;
          timeout_err_nxt = 1'b1;
          state_nxt       = ST_IDLE;
        end else if (wd_cnt != WD_MAX) begin
          wd_cnt_nxt = wd_cnt + 1'b1;
        end
      end
      ST_RESP: begin
        grant_nxt = '0;
        state_nxt = ST_IDLE;
      end
      default: begin
        grant_nxt     = '0;
        mem_rd_en_nxt = 1'b0;
        state_nxt     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      last           <= LAST_RST;
      wd_cnt         <= '0;
      grant          <= '0;
      req_data       <= '0;
      req_data_valid <= '0;
      mem_rd_en      <= 1'b0;
      mem_addr       <= '0;
      timeout_err    <= 1'b0;
    end else begin
      state          <= state_nxt;
      last           <= last_nxt;
      wd_cnt         <= wd_cnt_nxt;
      grant          <= grant_nxt;
      req_data       <= req_data_nxt;
      req_data_valid <= req_data_valid_nxt;
      mem_rd_en      <= mem_rd_en_nxt;
      mem_addr       <= mem_addr_nxt;
      timeout_err    <= timeout_err_nxt;
    end
  end

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Directed bench for mem_refill_arbiter: two requesters, TIMEOUT of 4.
module tb_mem_refill_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_rd_en;
  logic [63:0] req_addr;
  logic [1:0]  grant;
  logic [63:0] req_data;
  logic [1:0]  req_data_valid;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [63:0] mem_data;
  logic        mem_data_valid;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  mem_refill_arbiter #(
    .NUM_REQ   (2),
    .ADDR_WIDTH(32),
    .DATA_WIDTH(64),
    .TIMEOUT   (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_rd_en     (req_rd_en),
    .req_addr      (req_addr),
    .grant         (grant),
    .req_data      (req_data),
    .req_data_valid(req_data_valid),
    .mem_rd_en     (mem_rd_en),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .mem_data_valid(mem_data_valid),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag, input logic [63:0] data_exp);
    check_val({tag, "_grant"}, 64'(grant), 64'h0);
    check_val({tag, "_rdv"}, 64'(req_data_valid), 64'h0);
    check_val({tag, "_rden"}, 64'(mem_rd_en), 64'h0);
    check_val({tag, "_terr"}, 64'(timeout_err), 64'h0);
    check_val({tag, "_data"}, req_data, data_exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    req_rd_en      = 2'b00;
    req_addr       = 64'h0;
    mem_data       = 64'h0;
    mem_data_valid = 1'b0;
    tick();
    tick();
    check_idle_outputs("rst", 64'h0);
    check_val("rst_addr", 64'(mem_addr), 64'h0);
    rst = 1'b0;
    tick();
    check_idle_outputs("post_rst", 64'h0);

    // Single request, response on the third BUSY edge.
    req_addr  = {32'h0, 32'h0000_1238};
    req_rd_en = 2'b01;
    tick();
    check_val("s_grant", 64'(grant), 64'h1);
    check_val("s_addr", 64'(mem_addr), 64'h1238);
    check_val("s_rden", 64'(mem_rd_en), 64'h1);
    tick();
    tick();
    check_val("s_rden_hold", 64'(mem_rd_en), 64'h1);
    check_val("s_rdv_early", 64'(req_data_valid), 64'h0);
    mem_data       = 64'hDEAD_BEEF_0000_0001;
    mem_data_valid = 1'b1;
    tick();
    check_val("s_rdv", 64'(req_data_valid), 64'h1);
    check_val("s_data", req_data, 64'hDEAD_BEEF_0000_0001);
    check_val("s_rden_low", 64'(mem_rd_en), 64'h0);
    mem_data_valid = 1'b0;
    req_rd_en      = 2'b00;
    tick();
    check_val("s_rdv_once", 64'(req_data_valid), 64'h0);
    check_val("s_grant_rel", 64'(grant), 64'h0);
    // Stray valid in IDLE is ignored.
    mem_data       = 64'h1111_2222_3333_4444;
    mem_data_valid = 1'b1;
    tick();
    mem_data_valid = 1'b0;
    check_idle_outputs("stray", 64'hDEAD_BEEF_0000_0001);

    // Contention after reset: 0, then 1, then 0 again.
    do_reset();
    req_addr  = {32'h0000_00B0, 32'h0000_00A0};
    req_rd_en = 2'b11;
    tick();
    check_val("c1_grant", 64'(grant), 64'h1);
    check_val("c1_addr", 64'(mem_addr), 64'hA0);
    mem_data       = 64'hC1;
    mem_data_valid = 1'b1;
    tick();
    check_val("c1_rdv", 64'(req_data_valid), 64'h1);
    mem_data_valid = 1'b0;
    req_rd_en      = 2'b10;
    tick();
    check_val("c1_gap", 64'(grant), 64'h0);
    tick();
    check_val("c2_grant", 64'(grant), 64'h2);
    check_val("c2_addr", 64'(mem_addr), 64'hB0);
    mem_data       = 64'hC2;
    mem_data_valid = 1'b1;
    tick();
    check_val("c2_rdv", 64'(req_data_valid), 64'h2);
    check_val("c2_data", req_data, 64'hC2);
    mem_data_valid = 1'b0;
    req_rd_en      = 2'b01;
    tick();
    check_val("c2_gap", 64'(grant), 64'h0);
    tick();
    check_val("c3_grant", 64'(grant), 64'h1);
    mem_data       = 64'hC3;
    mem_data_valid = 1'b1;
    tick();
    check_val("c3_rdv", 64'(req_data_valid), 64'h1);
    mem_data_valid = 1'b0;
    req_rd_en      = 2'b00;
    tick();

    // Address freeze and withdrawal by requester 1 (last owner was 0).
    req_addr  = {32'h0000_0040, 32'h0};
    req_rd_en = 2'b10;
    tick();
    check_val("f_grant", 64'(grant), 64'h2);
    check_val("f_addr", 64'(mem_addr), 64'h40);
    req_addr  = {32'h0000_0080, 32'h0};
    req_rd_en = 2'b00;
    tick();
    check_val("f_addr_frozen", 64'(mem_addr), 64'h40);
    check_val("f_rden", 64'(mem_rd_en), 64'h1);
    tick();
    mem_data       = 64'hF00D_0000_0000_0040;
    mem_data_valid = 1'b1;
    tick();
    check_val("f_rdv", 64'(req_data_valid), 64'h2);
    check_val("f_data", req_data, 64'hF00D_0000_0000_0040);
    check_val("f_addr_end", 64'(mem_addr), 64'h40);
    mem_data_valid = 1'b0;
    tick();
    tick();
    check_val("f_idle", 64'(grant), 64'h0);

    // Watchdog: requester 0 at 0x100, memory silent.
    req_addr  = {32'h0000_0200, 32'h0000_0100};
    req_rd_en = 2'b01;
    tick();
    check_val("w_grant", 64'(grant), 64'h1);
    tick();
    tick();
    tick();
    check_val("w_no_err_3", 64'(timeout_err), 64'h0);
    check_val("w_rden_3", 64'(mem_rd_en), 64'h1);
    tick();
    check_val("w_err", 64'(timeout_err), 64'h1);
    check_val("w_rden_off", 64'(mem_rd_en), 64'h0);
    check_val("w_grant_off", 64'(grant), 64'h0);
    req_rd_en = 2'b11;
    tick();
    check_val("w_err_once", 64'(timeout_err), 64'h0);
    check_val("w_regrant1", 64'(grant), 64'h2);
    check_val("w_addr1", 64'(mem_addr), 64'h200);
    tick();
    tick();
    tick();
    mem_data       = 64'h4444_0000_0000_0004;
    mem_data_valid = 1'b1;
    tick();
    check_val("w4_rdv", 64'(req_data_valid), 64'h2);
    check_val("w4_no_err", 64'(timeout_err), 64'h0);
    check_val("w4_data", req_data, 64'h4444_0000_0000_0004);
    mem_data_valid = 1'b0;
    req_rd_en      = 2'b01;
    tick();
    tick();
    check_val("w_retry0", 64'(grant), 64'h1);
    check_val("w_retry_addr", 64'(mem_addr), 64'h100);
    tick();
    tick();
    tick();
    tick();
    check_val("w_err2", 64'(timeout_err), 64'h1);
    tick();
    check_val("w_retry_again", 64'(grant), 64'h1);
    check_val("w_retry_rden", 64'(mem_rd_en), 64'h1);

    // Reset mid-BUSY, then a late response must be ignored.
    #1;
    rst       = 1'b1;
    req_rd_en = 2'b00;
    #1;
    check_idle_outputs("ar", 64'h0);
    check_val("ar_addr", 64'(mem_addr), 64'h0);
    tick();
    rst = 1'b0;
    tick();
    mem_data       = 64'h5555_5555_5555_5555;
    mem_data_valid = 1'b1;
    tick();
    mem_data_valid = 1'b0;
    check_idle_outputs("ar_late", 64'h0);
    tick();
    check_val("ar_late2_rdv", 64'(req_data_valid), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_refill_arbiter.md
# mem_refill_arbiter

Shares the single backing-memory read port between several cache controllers, such as separate instruction and data caches. Each controller raises a level read request with an address when it misses. This block grants one requester at a time in round-robin order and drives the memory-side `mem_rd_en`/`mem_addr`. It returns the `mem_data` beat to the granted requester, and a per-transaction watchdog prevents a lost memory response from hanging all requesters.

## Interface
- `NUM_REQ`, 2: number of requesters, ≥2.
- `ADDR_WIDTH`, 32: memory address width.
- `DATA_WIDTH`, 64: memory data width (one cache line per beat).
- `TIMEOUT`, 255: maximum BUSY cycles to wait for `mem_data_valid`; 0 disables the watchdog.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_rd_en`  in  NUM_REQ  per-requester read request (level); requester i drives bit i.
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  requester i address in slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `grant`  out  NUM_REQ  one-hot (or zero) indicating the current owner of the memory port.
- `req_data`  out  DATA_WIDTH  returned line, broadcast to all requesters.
- `req_data_valid`  out  NUM_REQ  one-hot one-cycle pulse; `req_data` is valid for that requester.
- `mem_rd_en`  out  1  memory read request, held high until the response arrives.
- `mem_addr`  out  ADDR_WIDTH  latched address of the granted requester.
- `mem_data`  in  DATA_WIDTH  memory read data.
- `mem_data_valid`  in  1  `mem_data` is valid this cycle.
- `timeout_err`  out  1  one-cycle pulse when the watchdog fires.

## Operation
- States:
  - IDLE: no owner.
  - BUSY: request outstanding at memory.
  - RESP: data returned to the owner.
- Round-robin pointer `last` holds the most recently granted index. The search starts at `last+1` and wraps modulo NUM_REQ. On reset `last` = NUM_REQ-1, so requester 0 wins first.
- IDLE, any `req_rd_en` bit set:
  - select the winner and set `grant` one-hot;
  - latch its `req_addr` into `mem_addr`;
  - set `mem_rd_en`=1, `last`=winner, clear the watchdog counter;
  - go to BUSY.
- IDLE, no requests: outputs hold at their idle values (`grant`=0, `mem_rd_en`=0).
- BUSY, `mem_data_valid`=1:
  - capture `req_data`=`mem_data`;
  - set `req_data_valid`=`grant`;
  - clear `mem_rd_en`;
  - go to RESP.
- BUSY, `mem_data_valid`=0: increment the watchdog counter. If TIMEOUT≠0 and this is the TIMEOUT-th BUSY cycle without valid:
  - clear `mem_rd_en` and `grant`;
  - pulse `timeout_err`;
  - go to IDLE.
  
  The requester still holds its request and is retried later in round-robin order; others get priority first.
- RESP: clear `req_data_valid` and `grant`, then go to IDLE. `req_data` holds its value until the next capture.
- The address and owner are frozen for the whole transaction. Changes to `req_addr` are ignored.
- If the owner drops `req_rd_en` while BUSY, the transaction still completes and `req_data_valid` still pulses.
- `mem_data_valid` in IDLE or RESP is ignored: no output changes.
- `mem_data_valid` in the same cycle the watchdog would fire: the data wins, and `timeout_err` does not pulse.
- Watchdog counter width is $clog2(TIMEOUT+1); it saturates and never wraps.

## Timing
- Reset (async assert, any state):
  - outputs: `grant`=0, `req_data_valid`=0, `req_data`=0, `mem_rd_en`=0, `mem_addr`=0, `timeout_err`=0;
  - internal: state=IDLE, `last`=NUM_REQ-1, counter=0.
  
  An in-flight transaction is abandoned, and a later `mem_data_valid` is ignored.
- A request sampled at edge E0 in IDLE produces `grant`, `mem_rd_en`=1 and `mem_addr` after E0.
- `mem_data_valid` sampled at edge Ek produces `req_data_valid` pulse, `req_data` and `mem_rd_en`=0 after Ek.
- After Ek+1 the block is in IDLE. The earliest next grant is after Ek+2.
- The requester must deassert `req_rd_en` at the edge after it sees `req_data_valid`. Otherwise it is re-granted, which is a legal new read.
- Memory-side requirement: `mem_rd_en` is a level that stays high from grant until `mem_data_valid` is sampled.
- Watchdog: `timeout_err` goes high after the TIMEOUT-th BUSY edge and lasts exactly one cycle.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Single request: requester 0 requests `0x0000_1238`, memory returns `0xDEAD_BEEF_0000_0001` three cycles later. Expect:
  - `grant`=01 and `mem_addr`=`0x1238` one cycle after the request;
  - `req_data_valid`=01 for exactly one cycle carrying that data;
  - `mem_rd_en` low the cycle after valid.
- Contention: both requesters request in the same cycle after reset. Expect grant order 0, then 1, then 0 again if 0 re-requests, with no overlap of `grant` bits.
- Address freeze and withdrawal: requester 1 is granted at `0x40`, then changes its address to `0x80` and drops its request mid-BUSY. Expect `mem_addr` to stay `0x40` and `req_data_valid`=10 still to pulse.
- Watchdog: TIMEOUT=4, memory never responds. Expect:
  - `timeout_err` pulse after the 4th BUSY edge;
  - `mem_rd_en`=0;
  - re-grant to requester 1 if it is pending, otherwise a retry of requester 0.
  
  Then, with `mem_data_valid` on the 4th cycle, expect data delivered and no error.
- Reset mid-BUSY: assert `rst` while `mem_rd_en`=1, release it, then pulse `mem_data_valid`. Expect all outputs 0 immediately on reset, and no `req_data_valid` afterward.
